// File: rtl/mc_ctrl_fsm.sv
// Main control FSM for the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback
// over a req/ready memory handshake with a per-access bus timeout and a sticky trap state.
module mc_ctrl_fsm #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter bit          EN_JALR     = 1'b1,
  parameter bit          EN_AUIPC    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       mem_ready,
  output logic [1:0] sel_alu_src_a,
  output logic [1:0] sel_alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] sel_result,
  output logic       sel_mem_addr,
  output logic       mem_req,
  output logic       we_mem,
  output logic       we_ir,
  output logic       pc_update,
  output logic       branch,
  output logic       we_rf,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXE_ADDR, S_MEM_RD, S_WB_MEM, S_MEM_WR, S_EXE_R, S_WB_ALU,
    S_BRANCH, S_EXE_I, S_JAL, S_JALR, S_JALR_LINK, S_LUI, S_AUIPC, S_TRAP
  } state_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  // A zero timeout disables the counter; keep it one bit wide and parked at zero.
  localparam int unsigned  CW  = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    cause_q, cause_d;
  logic          mem_phase, timed_out;

  assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timed_out = (MEM_TIMEOUT != 0) && (cnt_q == TMO);

  // NOTE: state is held in flops updated only with non-blocking assignments; the reset is
  // asynchronous so an access in flight is abandoned the moment rst falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  // NOTE: every signal written in a combinational block gets a default first so no latch forms.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    cause_d = cause_q;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_EXE_ADDR;
          OP_R:         state_d = S_EXE_R;
          OP_I:         state_d = S_EXE_I;
          OP_B:         state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = EN_JALR ? S_JALR : S_TRAP;
          OP_LUI:       state_d = S_LUI;
          OP_AUIPC:     state_d = EN_AUIPC ? S_AUIPC : S_TRAP;
          default:      state_d = S_TRAP;
        endcase
        if (state_d == S_TRAP) cause_d = 2'b01;
      end
      S_EXE_ADDR: state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_WB_MEM;
      S_WB_MEM:   if (mem_ready) state_d = S_FETCH;
      S_MEM_WR:   state_d = S_FETCH;
      S_EXE_R, S_EXE_I, S_LUI, S_AUIPC, S_JAL: state_d = S_WB_ALU;
      S_WB_ALU, S_BRANCH: state_d = S_FETCH;
      S_JALR:      state_d = S_JALR_LINK;
      S_JALR_LINK: state_d = S_WB_ALU;
      default:     state_d = S_TRAP;
    endcase
    // Bus states hold while memory is busy; a ready in the final allowed cycle still completes.
    if (mem_phase && !mem_ready) begin
      if (timed_out) begin
        state_d = S_TRAP;
        cause_d = 2'b10;
      end else begin
        state_d = state_q;
        if (MEM_TIMEOUT != 0) cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    sel_alu_src_a = 2'b00;
    sel_alu_src_b = 2'b00;
    alu_op        = 2'b00;
    sel_result    = 2'b00;
    sel_mem_addr  = 1'b0;
    mem_req       = 1'b0;
    we_mem        = 1'b0;
    we_ir         = 1'b0;
    pc_update     = 1'b0;
    branch        = 1'b0;
    we_rf         = 1'b0;
    case (state_q)
      S_FETCH: begin
        sel_alu_src_b = 2'b10;
        sel_result    = 2'b10;
        mem_req       = 1'b1;
        we_ir         = mem_ready;
        pc_update     = mem_ready;
      end
      S_DECODE:    begin sel_alu_src_a = 2'b01; sel_alu_src_b = 2'b01; end
      S_EXE_ADDR:  begin sel_alu_src_a = 2'b10; sel_alu_src_b = 2'b01; end
      S_MEM_RD:    begin mem_req = 1'b1; sel_mem_addr = 1'b1; end
      S_WB_MEM:    begin sel_result = 2'b01; we_rf = mem_ready; end
      S_MEM_WR:    begin mem_req = 1'b1; we_mem = 1'b1; sel_mem_addr = 1'b1; end
      S_EXE_R:     begin sel_alu_src_a = 2'b10; alu_op = 2'b10; end
      S_EXE_I:     begin sel_alu_src_a = 2'b10; sel_alu_src_b = 2'b01; alu_op = 2'b10; end
      S_LUI:       begin sel_alu_src_a = 2'b11; sel_alu_src_b = 2'b01; end
      S_AUIPC:     begin sel_alu_src_a = 2'b01; sel_alu_src_b = 2'b01; end
      S_WB_ALU:    we_rf = 1'b1;
      S_BRANCH:    begin sel_alu_src_a = 2'b10; alu_op = 2'b01; branch = 1'b1; end
      S_JAL:       begin sel_alu_src_a = 2'b01; sel_alu_src_b = 2'b10; pc_update = 1'b1; end
      S_JALR: begin
        sel_alu_src_a = 2'b10;
        sel_alu_src_b = 2'b01;
        sel_result    = 2'b10;
        pc_update     = 1'b1;
      end
      S_JALR_LINK: begin sel_alu_src_a = 2'b01; sel_alu_src_b = 2'b10; end
      default: ;
    endcase
    if (!rst) begin
      mem_req   = 1'b0;
      we_mem    = 1'b0;
      we_ir     = 1'b0;
      pc_update = 1'b0;
      branch    = 1'b0;
      we_rf     = 1'b0;
    end
  end

  assign trap       = (state_q == S_TRAP);
  assign trap_cause = trap ? cause_q : 2'b00;
  assign state_o    = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Scoreboard bench for mc_ctrl_fsm: a full-feature instance and a stripped one (no JALR/AUIPC,
// timeout disabled) run against an instruction-plan reference model.
module tb_mc_ctrl_fsm;

  localparam int FETCH = 0, DECODE = 1, EXE_ADDR = 2, MEM_RD = 3, WB_MEM = 4, MEM_WR = 5,
                 EXE_R = 6, WB_ALU = 7, BRANCH = 8, EXE_I = 9, JAL = 10, JALR = 11,
                 JALR_LINK = 12, LUI = 13, AUIPC = 14, TRAP = 15;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011,
                         BT = 7'b1100011, JALO = 7'b1101111, JALRO = 7'b1100111,
                         LUIO = 7'b0110111, AUIPCO = 7'b0010111;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_ready;
  logic [6:0] op_a, op_b;

  logic [1:0] a_sa, a_sb, a_ao, a_rs, a_tc, b_sa, b_sb, b_ao, b_rs, b_tc;
  logic       a_ad, a_rq, a_wm, a_wi, a_pc, a_br, a_wr, a_tr;
  logic       b_ad, b_rq, b_wm, b_wi, b_pc, b_br, b_wr, b_tr;
  logic [3:0] a_st, b_st;
  logic [21:0] obs_a, obs_b;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MEM_TIMEOUT(15), .EN_JALR(1'b1), .EN_AUIPC(1'b1)) dut_a (
    .clk(clk), .rst(rst), .op(op_a), .mem_ready(mem_ready),
    .sel_alu_src_a(a_sa), .sel_alu_src_b(a_sb), .alu_op(a_ao), .sel_result(a_rs),
    .sel_mem_addr(a_ad), .mem_req(a_rq), .we_mem(a_wm), .we_ir(a_wi), .pc_update(a_pc),
    .branch(a_br), .we_rf(a_wr), .trap(a_tr), .trap_cause(a_tc), .state_o(a_st));

  mc_ctrl_fsm #(.MEM_TIMEOUT(0), .EN_JALR(1'b0), .EN_AUIPC(1'b0)) dut_b (
    .clk(clk), .rst(rst), .op(op_b), .mem_ready(mem_ready),
    .sel_alu_src_a(b_sa), .sel_alu_src_b(b_sb), .alu_op(b_ao), .sel_result(b_rs),
    .sel_mem_addr(b_ad), .mem_req(b_rq), .we_mem(b_wm), .we_ir(b_wi), .pc_update(b_pc),
    .branch(b_br), .we_rf(b_wr), .trap(b_tr), .trap_cause(b_tc), .state_o(b_st));

  assign obs_a = {a_sa, a_sb, a_ao, a_rs, a_ad, a_rq, a_wm, a_wi, a_pc, a_br, a_wr, a_tr, a_tc, a_st};
  assign obs_b = {b_sa, b_sb, b_ao, b_rs, b_ad, b_rq, b_wm, b_wi, b_pc, b_br, b_wr, b_tr, b_tc, b_st};

  // Reference model: each instance keeps the list of states its current instruction still has
  // to visit; the head is the current state.
  int m_plan[2][4];
  int m_len[2];
  int m_wait[2];
  int m_cause[2];

  function automatic int tmo_of(input int k);
    return (k == 0) ? 15 : 0;
  endfunction

  function automatic bit ext_on(input int k);
    return (k == 0);
  endfunction

  task automatic set_plan(input int k, input int n, input int s0, input int s1, input int s2);
    m_plan[k][0] = s0; m_plan[k][1] = s1; m_plan[k][2] = s2; m_plan[k][3] = 0;
    m_len[k] = n;
  endtask

  task automatic model_reset(input int k);
    set_plan(k, 1, FETCH, 0, 0);
    m_wait[k]  = 0;
    m_cause[k] = 0;
  endtask

  task automatic plan_for_op(input int k, input logic [6:0] o);
    case (o)
      LW:     set_plan(k, 3, EXE_ADDR, MEM_RD, WB_MEM);
      SW:     set_plan(k, 2, EXE_ADDR, MEM_WR, 0);
      RT:     set_plan(k, 2, EXE_R, WB_ALU, 0);
      IT:     set_plan(k, 2, EXE_I, WB_ALU, 0);
      BT:     set_plan(k, 1, BRANCH, 0, 0);
      JALO:   set_plan(k, 2, JAL, WB_ALU, 0);
      LUIO:   set_plan(k, 2, LUI, WB_ALU, 0);
      JALRO:  if (ext_on(k)) set_plan(k, 3, JALR, JALR_LINK, WB_ALU);
              else begin set_plan(k, 1, TRAP, 0, 0); m_cause[k] = 1; end
      AUIPCO: if (ext_on(k)) set_plan(k, 2, AUIPC, WB_ALU, 0);
              else begin set_plan(k, 1, TRAP, 0, 0); m_cause[k] = 1; end
      default: begin set_plan(k, 1, TRAP, 0, 0); m_cause[k] = 1; end
    endcase
  endtask

  task automatic model_step(input int k, input logic rdy, input logic [6:0] o);
    int s;
    s = m_plan[k][0];
    if (s == TRAP) return;
    if ((s == FETCH || s == MEM_RD || s == MEM_WR || s == WB_MEM) && !rdy) begin
      if (s != WB_MEM && tmo_of(k) != 0) begin
        if (m_wait[k] == tmo_of(k)) begin
          set_plan(k, 1, TRAP, 0, 0);
          m_cause[k] = 2;
        end else m_wait[k]++;
      end
      return;
    end
    m_wait[k] = 0;
    for (int i = 0; i < 3; i++) m_plan[k][i] = m_plan[k][i+1];
    m_len[k]--;
    if (s == FETCH) set_plan(k, 1, DECODE, 0, 0);
    else if (s == DECODE) plan_for_op(k, o);
    if (m_len[k] == 0) set_plan(k, 1, FETCH, 0, 0);
  endtask

  // Expected outputs for the model's current state; mask marks which select fields are defined.
  task automatic expect_out(input int k, input logic rdy, input logic rv,
                            output logic [21:0] e, output logic [21:0] m);
    logic [1:0] sa, sb, ao, rs;
    logic       ad, rq, wm, wi, pc, br, wr;
    logic [4:0] fm;
    int         s;
    sa = 0; sb = 0; ao = 0; rs = 0; ad = 0; rq = 0; wm = 0; wi = 0; pc = 0; br = 0; wr = 0;
    fm = 5'b00000;
    s  = rv ? m_plan[k][0] : FETCH;
    case (s)
      FETCH:     begin sa = 0; sb = 2; ao = 0; rs = 2; ad = 0; fm = 5'b11111;
                       rq = 1; wi = rdy; pc = rdy; end
      DECODE:    begin sa = 1; sb = 1; ao = 0; fm = 5'b11100; end
      EXE_ADDR:  begin sa = 2; sb = 1; ao = 0; fm = 5'b11100; end
      MEM_RD:    begin ad = 1; fm = 5'b00001; rq = 1; end
      WB_MEM:    begin rs = 1; fm = 5'b00010; wr = rdy; end
      MEM_WR:    begin ad = 1; fm = 5'b00001; rq = 1; wm = 1; end
      EXE_R:     begin sa = 2; sb = 0; ao = 2; fm = 5'b11100; end
      EXE_I:     begin sa = 2; sb = 1; ao = 2; fm = 5'b11100; end
      LUI:       begin sa = 3; sb = 1; ao = 0; fm = 5'b11100; end
      AUIPC:     begin sa = 1; sb = 1; ao = 0; fm = 5'b11100; end
      WB_ALU:    begin rs = 0; fm = 5'b00010; wr = 1; end
      BRANCH:    begin sa = 2; sb = 0; ao = 1; rs = 0; fm = 5'b11110; br = 1; end
      JAL:       begin sa = 1; sb = 2; ao = 0; rs = 0; fm = 5'b11110; pc = 1; end
      JALR:      begin sa = 2; sb = 1; ao = 0; rs = 2; fm = 5'b11110; pc = 1; end
      JALR_LINK: begin sa = 1; sb = 2; ao = 0; fm = 5'b11100; end
      default: ;
    endcase
    if (!rv) begin rq = 0; wm = 0; wi = 0; pc = 0; br = 0; wr = 0; end
    e = {sa, sb, ao, rs, ad, rq, wm, wi, pc, br, wr, (s == TRAP),
         (s == TRAP) ? 2'(m_cause[k]) : 2'b00, 4'(s)};
    m = {{2{fm[4]}}, {2{fm[3]}}, {2{fm[2]}}, {2{fm[1]}}, fm[0], 13'h1fff};
  endtask

  typedef struct packed {
    logic [21:0] ea, ma, eb, mb;
  } exp_t;

  exp_t  sb_q[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  string tag = "init";

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] ex,
                       input logic [21:0] m);
    vectors++;
    if ((act & m) != (ex & m)) begin
      miscompares++;
      $display("FAIL %s/%s cycle %0d: got %h, expected %h (mask %h)", tag, name, cyc,
               act & m, ex & m, m);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("full", obs_a, e.ea, e.ma);
      check("lite", obs_b, e.eb, e.mb);
    end
  end

  // One clock cycle of stimulus: drive inputs, queue the expectation, then advance the model.
  task automatic apply(input logic r, input logic rdy);
    exp_t e;
    logic [21:0] ex, mk;
    rst = r;
    mem_ready = rdy;
    expect_out(0, rdy, r, ex, mk); e.ea = ex; e.ma = mk;
    expect_out(1, rdy, r, ex, mk); e.eb = ex; e.mb = mk;
    sb_q.push_back(e);
    @(posedge clk);
    if (!r) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, rdy, op_a);
      model_step(1, rdy, op_b);
    end
    #1;
  endtask

  task automatic start(input string t, input logic [6:0] o);
    tag  = t;
    op_a = o;
    op_b = o;
    apply(1'b0, 1'b1);
  endtask

  function automatic logic [6:0] rand_op();
    logic [6:0] ops [9];
    ops = '{LW, SW, RT, IT, BT, JALO, JALRO, LUIO, AUIPCO};
    if ($urandom_range(15) == 0) return 7'($urandom);
    return ops[$urandom_range(8)];
  endfunction

  initial begin
    rst = 1'b0;
    mem_ready = 1'b0;
    op_a = RT;
    op_b = RT;
    model_reset(0);
    model_reset(1);
    @(posedge clk);
    #1;

    start("reset", RT);
    apply(1'b0, 1'b0);
    tag = "r_type";
    repeat (5) apply(1'b1, 1'b1);

    start("lw_wait", LW);
    repeat (3) apply(1'b1, 1'b1);
    repeat (3) apply(1'b1, 1'b0);
    repeat (3) apply(1'b1, 1'b1);

    start("illegal", 7'b0000000);
    repeat (2) apply(1'b1, 1'b1);
    repeat (3) apply(1'b1, 1'b0);
    repeat (2) apply(1'b1, 1'b1);

    start("fetch_tmo", RT);
    repeat (16) apply(1'b1, 1'b0);
    repeat (3) apply(1'b1, 1'b1);

    start("tmo_edge", IT);
    repeat (15) apply(1'b1, 1'b0);
    repeat (5) apply(1'b1, 1'b1);

    start("jalr", JALRO);
    repeat (7) apply(1'b1, 1'b1);

    start("auipc", AUIPCO);
    repeat (6) apply(1'b1, 1'b1);

    start("branch_jal", BT);
    repeat (4) apply(1'b1, 1'b1);
    op_a = JALO; op_b = JALO;
    repeat (4) apply(1'b1, 1'b1);

    start("rst_memwr", SW);
    repeat (3) apply(1'b1, 1'b1);
    repeat (2) apply(1'b1, 1'b0);
    repeat (2) apply(1'b0, 1'b0);
    repeat (3) apply(1'b1, 1'b1);

    start("random", RT);
    repeat (1500) begin
      if (m_plan[0][0] == FETCH) op_a = rand_op();
      if (m_plan[1][0] == FETCH) op_b = rand_op();
      if (((m_plan[0][0] == TRAP || m_plan[1][0] == TRAP) && $urandom_range(7) == 0) ||
          $urandom_range(199) == 0)
        apply(1'b0, 1'($urandom_range(1)));
      else
        apply(1'b1, 1'($urandom_range(9) < 7));
    end

    @(negedge clk);
    #1;
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
